pixel_xfer_ctrl: RTL and testbench

Command sequencer between the HPS pixel PIO words and the VGA framebuffer write/read port. Decodes toggle-handshaked 32-bit commands (set address, write pixel, read pixel) and auto-increments a framebuffer address. Yields the framebuffer port to VGA scanout whenever scanout claims it. Reports progress on the 32-bit words exported to the HPS as `pixel_status_export` and `pixel_data_export`.

---
 rtl/pixel_xfer_pkg.sv | 28 ++
 rtl/pixel_xfer_ctrl_addr_counter.sv | 45 ++++
 rtl/pixel_xfer_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_pixel_xfer_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_xfer_pkg.sv
// Shared types and constants for the HPS pixel command sequencer.
package pixel_xfer_pkg;

   localparam int unsigned NUM_PIXELS_DEF = 307200;

   localparam int unsigned ACK_BIT  = 31;
   localparam int unsigned BUSY_BIT = 30;
   localparam int unsigned ERR_BIT  = 29;
   localparam int unsigned WRAP_BIT = 28;

   typedef enum logic [1:0] {
      OP_NOP      = 2'b00,
      OP_SET_ADDR = 2'b01,
      OP_WRITE    = 2'b10,
      OP_READ     = 2'b11
   } opcode_e;

   typedef enum logic [2:0] {
      ST_INIT       = 3'd0,
      ST_IDLE       = 3'd1,
      ST_WAIT_PORT  = 3'd2,
      ST_WRITE      = 3'd3,
      ST_READ_ISSUE = 3'd4,
      ST_READ_WAIT  = 3'd5,
      ST_DONE       = 3'd6
   } state_e;

endpackage

// File: rtl/pixel_xfer_ctrl_addr_counter.sv
// Framebuffer address register: load, increment with wrap at NUM_PIXELS-1, sticky wrapped flag.
module pixel_addr_counter
   import pixel_xfer_pkg::*;
#(
   parameter int unsigned NUM_PIXELS = NUM_PIXELS_DEF,
   parameter int unsigned ADDR_W     = 19
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_load,
   input  logic [ADDR_W-1:0] i_load_addr,
   input  logic              i_inc,
   output logic [ADDR_W-1:0] o_addr,
   output logic              o_wrapped
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

   logic [ADDR_W-1:0] r_addr;
   logic              r_wrapped;
   logic              w_at_last;

   assign w_at_last = (r_addr == LAST_ADDR);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_addr    <= '0;
         r_wrapped <= 1'b0;
      end else if (i_load) begin
         r_addr    <= i_load_addr;
         r_wrapped <= 1'b0;
      end else if (i_inc) begin
         if (w_at_last) begin
            r_addr    <= '0;
            r_wrapped <= 1'b1;
         end else begin
            r_addr <= r_addr + ADDR_W'(1);
         end
      end
   end

   assign o_addr    = r_addr;
   assign o_wrapped = r_wrapped;

endmodule

// File: rtl/pixel_xfer_ctrl.sv
// HPS pixel command sequencer driving the VGA framebuffer port.
// Build option: define PIXEL_XFER_READBACK_EN to support the READ command.
module pixel_xfer_ctrl
   import pixel_xfer_pkg::*;
#(
   parameter int unsigned NUM_PIXELS = NUM_PIXELS_DEF,
   parameter int unsigned ADDR_W     = 19,
   parameter int unsigned PIXEL_W    = 8,
   parameter int unsigned RD_LAT     = 2
) (
   input  logic               clk_clk,
   input  logic               reset_reset_n,
   input  logic [31:0]        cmd_i,
   input  logic               fb_busy_i,
   output logic [ADDR_W-1:0]  fb_addr_o,
   output logic [PIXEL_W-1:0] fb_wdata_o,
   output logic               fb_we_o,
   output logic               fb_re_o,
   input  logic [PIXEL_W-1:0] fb_rdata_i,
   output logic [31:0]        status_o,
   output logic [31:0]        pixel_data_o
);

   logic [31:0]        r_cmd_q1;
   logic [31:0]        r_cmd_q2;
   state_e             r_state;
   opcode_e            r_op;
   logic [PIXEL_W-1:0] r_wdata;
   logic [ADDR_W-1:0]  r_fb_addr;
   logic               r_ack;
   logic               r_busy;
   logic               r_err;

   opcode_e            w_cmd_op;
   logic               w_pending;
   logic               w_legal;
   logic               w_load;
   logic               w_inc;
   logic [ADDR_W-1:0]  w_addr;
   logic               w_wrapped;
   logic               w_unused;

`ifdef PIXEL_XFER_READBACK_EN
   logic [2:0]         r_lat_cnt;
   logic [PIXEL_W-1:0] r_pix;
   logic               w_lat_done;
`endif

   // Input stages carry no reset so a toggle held through reset is already
   // visible when INIT samples it.
   always_ff @(posedge clk_clk) begin
      r_cmd_q1 <= cmd_i;
      r_cmd_q2 <= r_cmd_q1;
   end

   assign w_cmd_op  = opcode_e'(r_cmd_q2[30:29]);
   assign w_pending = (r_cmd_q2[31] != r_ack);
   assign w_legal   = (32'(r_cmd_q2[23:0]) < NUM_PIXELS);
   assign w_load    = (r_state == ST_IDLE) && w_pending &&
                      (w_cmd_op == OP_SET_ADDR) && w_legal;

`ifdef PIXEL_XFER_READBACK_EN
   assign w_lat_done = (r_lat_cnt == 3'(RD_LAT - 1));
   assign w_inc      = (r_state == ST_WRITE) ||
                       ((r_state == ST_READ_WAIT) && w_lat_done);
`else
   assign w_inc      = (r_state == ST_WRITE);
`endif

   pixel_addr_counter #(
      .NUM_PIXELS (NUM_PIXELS),
      .ADDR_W     (ADDR_W)
   ) u_addr_counter (
      .i_clk       (clk_clk),
      .i_rst_n     (reset_reset_n),
      .i_load      (w_load),
      .i_load_addr (r_cmd_q2[ADDR_W-1:0]),
      .i_inc       (w_inc),
      .o_addr      (w_addr),
      .o_wrapped   (w_wrapped)
   );

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_state   <= ST_INIT;
         r_op      <= OP_NOP;
         r_wdata   <= '0;
         r_fb_addr <= '0;
         r_ack     <= 1'b0;
         r_busy    <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         case (r_state)
            ST_INIT: begin
               r_ack   <= r_cmd_q2[31];
               r_state <= ST_IDLE;
            end
            ST_IDLE: begin
               if (w_pending) begin
                  r_op      <= w_cmd_op;
                  r_wdata   <= r_cmd_q2[PIXEL_W-1:0];
                  r_fb_addr <= w_addr;
                  r_busy    <= 1'b1;
                  case (w_cmd_op)
                     OP_SET_ADDR: begin
                        r_err   <= !w_legal;
                        r_state <= ST_DONE;
                     end
                     OP_WRITE: r_state <= ST_WAIT_PORT;
`ifdef PIXEL_XFER_READBACK_EN
                     OP_READ:  r_state <= ST_WAIT_PORT;
`else
                     OP_READ: begin
                        r_err   <= 1'b1;
                        r_state <= ST_DONE;
                     end
`endif
                     default:  r_state <= ST_DONE;
                  endcase
               end
            end
            ST_WAIT_PORT: begin
               if (!fb_busy_i) begin
`ifdef PIXEL_XFER_READBACK_EN
                  r_state <= (r_op == OP_READ) ? ST_READ_ISSUE : ST_WRITE;
`else
                  r_state <= ST_WRITE;
`endif
               end
            end
            ST_WRITE: r_state <= ST_DONE;
`ifdef PIXEL_XFER_READBACK_EN
            ST_READ_ISSUE: r_state <= ST_READ_WAIT;
            ST_READ_WAIT: begin
               if (w_lat_done) r_state <= ST_DONE;
            end
`endif
            ST_DONE: begin
               r_ack   <= ~r_ack;
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_INIT;
         endcase
      end
   end

`ifdef PIXEL_XFER_READBACK_EN
   // Latency counter runs only in READ_WAIT; data is taken on its last count.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_lat_cnt <= '0;
         r_pix     <= '0;
      end else if (r_state == ST_READ_WAIT) begin
         if (w_lat_done) begin
            r_pix     <= fb_rdata_i;
            r_lat_cnt <= '0;
         end else begin
            r_lat_cnt <= r_lat_cnt + 3'd1;
         end
      end else begin
         r_lat_cnt <= '0;
      end
   end

   assign fb_re_o      = (r_state == ST_READ_ISSUE);
   assign pixel_data_o = 32'(r_pix);
   assign w_unused     = ^r_cmd_q2[28:24];
`else
   assign fb_re_o      = 1'b0;
   assign pixel_data_o = '0;
   assign w_unused     = ^{r_cmd_q2[28:24], fb_rdata_i, r_op};
`endif

   assign fb_we_o    = (r_state == ST_WRITE);
   assign fb_wdata_o = fb_we_o ? r_wdata : '0;
   assign fb_addr_o  = r_fb_addr;

   always_comb begin
      status_o               = '0;
      status_o[ACK_BIT]      = r_ack;
      status_o[BUSY_BIT]     = r_busy;
      status_o[ERR_BIT]      = r_err;
      status_o[WRAP_BIT]     = w_wrapped;
      status_o[ADDR_W-1:0]   = w_addr;
   end

endmodule

// File: tb/tb_pixel_xfer_ctrl.sv
// Self-checking bench for pixel_xfer_ctrl: directed table, abort-on-reset sequence, random commands.
module tb_pixel_xfer_ctrl;

   localparam int unsigned NUM_PIXELS = 307200;
   localparam int unsigned RD_LAT     = 2;

   logic        clk_clk = 1'b0;
   logic        reset_reset_n;
   logic [31:0] cmd_i;
   logic        fb_busy_i;
   logic [18:0] fb_addr_o;
   logic [7:0]  fb_wdata_o;
   logic        fb_we_o;
   logic        fb_re_o;
   logic [7:0]  fb_rdata_i;
   logic [31:0] status_o;
   logic [31:0] pixel_data_o;

   pixel_xfer_ctrl #(
      .NUM_PIXELS (NUM_PIXELS),
      .ADDR_W     (19),
      .PIXEL_W    (8),
      .RD_LAT     (RD_LAT)
   ) dut (
      .clk_clk       (clk_clk),
      .reset_reset_n (reset_reset_n),
      .cmd_i         (cmd_i),
      .fb_busy_i     (fb_busy_i),
      .fb_addr_o     (fb_addr_o),
      .fb_wdata_o    (fb_wdata_o),
      .fb_we_o       (fb_we_o),
      .fb_re_o       (fb_re_o),
      .fb_rdata_i    (fb_rdata_i),
      .status_o      (status_o),
      .pixel_data_o  (pixel_data_o)
   );

   always #5 clk_clk = ~clk_clk;

   function automatic logic [7:0] mem_val(input logic [18:0] a);
      return a[7:0] ^ 8'h3B;
   endfunction

   // Framebuffer read model: data appears RD_LAT cycles after the strobe, junk otherwise.
   logic        m_v [RD_LAT];
   logic [18:0] m_a [RD_LAT];
   always @(posedge clk_clk) begin
      m_v[0] <= fb_re_o;
      m_a[0] <= fb_addr_o;
      for (int i = 1; i < RD_LAT; i++) begin
         m_v[i] <= m_v[i-1];
         m_a[i] <= m_a[i-1];
      end
   end
   assign fb_rdata_i = m_v[RD_LAT-1] ? mem_val(m_a[RD_LAT-1]) : 8'hEE;

   int unsigned we_cnt = 0;
   int unsigned re_cnt = 0;
   always @(posedge clk_clk) begin
      if (fb_we_o) we_cnt <= we_cnt + 1;
      if (fb_re_o) re_cnt <= re_cnt + 1;
   end

   int unsigned checks = 0;
   int unsigned errors = 0;

   // Reference state of the sequencer as seen by the host
   logic        tog;
   logic        m_ack;
   logic        m_err;
   logic        m_wrap;
   logic [18:0] m_addr;
   logic [7:0]  m_pix;
   int unsigned m_reads;

   function automatic logic [31:0] model_status();
      return {m_ack, 1'b0, m_err, m_wrap, 9'd0, m_addr};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
      end
   endtask

   task automatic do_cmd(input logic [1:0] op, input logic [23:0] pl, input int unsigned nb);
      int unsigned ack_e, strobe_e, pix_e;
      int unsigned bad_busy, bad_ack, bad_we, bad_re, bad_pix, bad_addr, bad_wd;
      logic [18:0] a0;
      logic [7:0]  pix_old, pix_new;
      logic        ack_old, is_wr, is_rd;
      logic        e_busy, e_ack, e_we, e_re;
      logic [7:0]  e_pix;
      a0 = m_addr; pix_old = m_pix; pix_new = m_pix; ack_old = m_ack;
      is_wr = 1'b0; is_rd = 1'b0; strobe_e = 0; pix_e = 0; ack_e = 3;
      bad_busy = 0; bad_ack = 0; bad_we = 0; bad_re = 0; bad_pix = 0; bad_addr = 0; bad_wd = 0;
      case (op)
         2'b01: begin
            if (32'(pl) < NUM_PIXELS) begin
               m_addr = pl[18:0]; m_err = 1'b0; m_wrap = 1'b0;
            end else begin
               m_err = 1'b1;
            end
         end
         2'b10: begin
            is_wr = 1'b1; strobe_e = 3 + nb; ack_e = 5 + nb;
            m_addr = 19'((32'(m_addr) + 1) % NUM_PIXELS);
            if (m_addr == 19'd0) m_wrap = 1'b1;
         end
         2'b11: begin
`ifdef PIXEL_XFER_READBACK_EN
            is_rd = 1'b1; strobe_e = 3 + nb; pix_e = 4 + nb + RD_LAT; ack_e = 5 + nb + RD_LAT;
            pix_new = mem_val(a0); m_pix = pix_new; m_reads++;
            m_addr = 19'((32'(m_addr) + 1) % NUM_PIXELS);
            if (m_addr == 19'd0) m_wrap = 1'b1;
`else
            m_err = 1'b1;
`endif
         end
         default: ;
      endcase
      m_ack = ~m_ack;

      @(negedge clk_clk);
      tog = ~tog;
      cmd_i = {tog, op, 5'd0, pl};
      fb_busy_i = 1'($urandom_range(0, 1));
      for (int unsigned e = 0; e <= ack_e + 1; e++) begin
         @(negedge clk_clk);
         e_busy = (e >= 2) && (e < ack_e);
         e_ack  = (e >= ack_e) ? m_ack : ack_old;
         e_we   = is_wr && (e == strobe_e);
         e_re   = is_rd && (e == strobe_e);
         e_pix  = (is_rd && e >= pix_e) ? pix_new : pix_old;
         if (status_o[30] !== e_busy) bad_busy++;
         if (status_o[31] !== e_ack) bad_ack++;
         if (fb_we_o !== e_we) bad_we++;
         if (fb_re_o !== e_re) bad_re++;
         if (pixel_data_o !== {24'd0, e_pix}) bad_pix++;
         if ((is_wr || is_rd) && e_busy && fb_addr_o !== a0) bad_addr++;
         if (e_we && fb_wdata_o !== pl[7:0]) bad_wd++;
         if (e >= 2 && e < 2 + nb)  fb_busy_i = 1'b1;
         else if (e == 2 + nb)      fb_busy_i = 1'b0;
         else                       fb_busy_i = 1'($urandom_range(0, 1));
      end
      chk($sformatf("busy_trace op%0d", op), bad_busy, 0);
      chk($sformatf("ack_trace op%0d nb%0d", op, nb), bad_ack, 0);
      chk($sformatf("we_trace op%0d nb%0d", op, nb), bad_we, 0);
      chk($sformatf("re_trace op%0d nb%0d", op, nb), bad_re, 0);
      chk($sformatf("pix_trace op%0d", op), bad_pix, 0);
      chk($sformatf("addr_stable op%0d", op), bad_addr, 0);
      chk($sformatf("wdata op%0d", op), bad_wd, 0);
      for (int i = 0; i < 100 && status_o[31] !== m_ack; i++) @(negedge clk_clk);
      chk($sformatf("status op%0d pl%06h", op, pl), status_o, model_status());
   endtask

   typedef struct {
      logic [1:0]  op;
      logic [23:0] pl;
      int unsigned nb;
      logic [30:0] st;
      logic [7:0]  pix;
   } vec_t;

   vec_t tbl [12];

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = '{2'b01, 24'd100,    0, 31'h0000_0064, 8'h00};
      tbl[1]  = '{2'b10, 24'h0000A5, 0, 31'h0000_0065, 8'h00};
      tbl[2]  = '{2'b01, 24'd307199, 0, 31'h0004_AFFF, 8'h00};
      tbl[3]  = '{2'b10, 24'h000011, 0, 31'h1000_0000, 8'h00};
      tbl[4]  = '{2'b01, 24'd5,      0, 31'h0000_0005, 8'h00};
      tbl[5]  = '{2'b01, 24'd307200, 0, 31'h2000_0005, 8'h00};
      tbl[6]  = '{2'b01, 24'd7,      0, 31'h0000_0007, 8'h00};
`ifdef PIXEL_XFER_READBACK_EN
      tbl[7]  = '{2'b11, 24'd0,      0, 31'h0000_0008, 8'h3C};
      tbl[8]  = '{2'b01, 24'd7,      0, 31'h0000_0007, 8'h3C};
      tbl[9]  = '{2'b10, 24'h00005A, 10, 31'h0000_0008, 8'h3C};
      tbl[10] = '{2'b00, 24'd0,      0, 31'h0000_0008, 8'h3C};
      tbl[11] = '{2'b11, 24'd0,      3, 31'h0000_0009, 8'h33};
`else
      tbl[7]  = '{2'b11, 24'd0,      0, 31'h2000_0007, 8'h00};
      tbl[8]  = '{2'b01, 24'd7,      0, 31'h0000_0007, 8'h00};
      tbl[9]  = '{2'b10, 24'h00005A, 10, 31'h0000_0008, 8'h00};
      tbl[10] = '{2'b00, 24'd0,      0, 31'h0000_0008, 8'h00};
      tbl[11] = '{2'b11, 24'd0,      3, 31'h2000_0008, 8'h00};
`endif

      // Toggle held high through reset must not run a command
      reset_reset_n = 1'b0;
      cmd_i = 32'h8000_0000;
      fb_busy_i = 1'b0;
      tog = 1'b1;
      repeat (4) @(posedge clk_clk);
      #1;
      chk("rst_status", status_o, 32'h0);
      chk("rst_strobes", {30'd0, fb_we_o, fb_re_o}, 32'h0);
      chk("rst_addr", {13'd0, fb_addr_o}, 32'h0);
      chk("rst_pix", pixel_data_o, 32'h0);
      @(negedge clk_clk);
      reset_reset_n = 1'b1;
      repeat (6) @(negedge clk_clk);
      chk("init_status", status_o, 32'h8000_0000);
      chk("init_no_strobe", we_cnt + re_cnt, 0);
      m_ack = 1'b1; m_err = 1'b0; m_wrap = 1'b0; m_addr = '0; m_pix = '0; m_reads = 0;

      for (int n = 0; n < 12; n++) begin
         do_cmd(tbl[n].op, tbl[n].pl, tbl[n].nb);
         chk($sformatf("tbl%0d_status", n), {1'b0, status_o[30:0]}, {1'b0, tbl[n].st});
         chk($sformatf("tbl%0d_pix", n), pixel_data_o, {24'd0, tbl[n].pix});
      end

      // Reset while a WRITE waits for the port: no strobe, no ack
      begin
         int unsigned we_before;
         @(negedge clk_clk);
         tog = ~tog;
         cmd_i = {tog, 2'b10, 5'd0, 24'h000077};
         fb_busy_i = 1'b1;
         repeat (4) @(negedge clk_clk);
         chk("abort_busy", {31'd0, status_o[30]}, 32'h1);
         we_before = we_cnt;
         #2 reset_reset_n = 1'b0;
         #1;
         chk("abort_status", status_o, 32'h0);
         chk("abort_outputs", {5'd0, fb_we_o, fb_re_o, fb_addr_o, fb_wdata_o}, 32'h0);
         repeat (3) @(negedge clk_clk);
         fb_busy_i = 1'b0;
         reset_reset_n = 1'b1;
         repeat (4) @(negedge clk_clk);
         chk("abort_no_write", we_cnt, we_before);
         chk("abort_status_after", status_o, {tog, 31'd0});
         m_ack = tog; m_err = 1'b0; m_wrap = 1'b0; m_addr = '0; m_pix = '0;
      end

      for (int n = 0; n < 40; n++) begin
         int unsigned r, sel;
         logic [1:0]  op;
         logic [23:0] pl;
         r = $urandom_range(0, 9);
         op = (r < 3) ? 2'b01 : (r < 6) ? 2'b10 : (r < 8) ? 2'b11 : 2'b00;
         pl = 24'($urandom);
         if (op == 2'b01) begin
            sel = $urandom_range(0, 3);
            if (sel == 0)      pl = 24'(NUM_PIXELS - 1 - $urandom_range(0, 3));
            else if (sel == 1) pl = 24'(NUM_PIXELS + $urandom_range(0, 5000));
            else               pl = 24'($urandom_range(0, NUM_PIXELS - 1));
         end
         do_cmd(op, pl, $urandom_range(0, 4));
      end

      chk("read_strobe_count", re_cnt, m_reads);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
